poly_product_accumulator: RTL and testbench

POLY_PRODUCT_ACCUMULATOR -- requirements
Module: poly_product_accumulator

---
 rtl/poly_product_accumulator.sv | 173 +++++++++++++++++
 tb/tb_poly_product_accumulator.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_product_accumulator.sv
// poly_product_accumulator: accumulates partial-product beats into a DEPTH-entry ring, then streams the ring out.
// Latency: a beat lands in the array 2 cycles after acceptance; DRAIN starts 2 cycles after the B_last beat.
// Backpressure: none on input (one beat per cycle in ACCUM); output is valid/ready and holds while stalled.
//
// Ports: clk_in/rst_in (async active-high), start (clear + begin), B_valid/idx_B/B_out/B_last (beat input),
//        out_valid/out_ready/out_idx/out_coeff (coefficient stream), busy, done (1-cycle pulse), err (sticky).
// Build option: define ACC_NEGACYCLIC_EN to subtract wrapped lanes (x^DEPTH = -1); default build adds them.
module poly_product_accumulator #(
   parameter int DEPTH = 784,
   parameter int LANES = 7,
   parameter int CW    = 6
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                start,
   input  logic                B_valid,
   input  logic [10:0]         idx_B,
   input  logic [LANES*CW-1:0] B_out,
   input  logic                B_last,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [9:0]          out_idx,
   output logic [CW-1:0]       out_coeff,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_FLUSH,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic                  s1_vld_q, s1_vld_d;
   logic [10:0]           s1_idx_q, s1_idx_d;
   logic [LANES*CW-1:0]   s1_dat_q, s1_dat_d;
   logic [AW-1:0]         out_idx_q, out_idx_d;
   logic                  err_q, err_d;
   logic                  clr;
   logic                  beat_oor;
   logic [CW-1:0]         mem_q [DEPTH];
   logic [CW-1:0]         mem_d [DEPTH];

   // stage-2 per-lane scratch
   logic [12:0]           tsum;
   logic                  wrap;
   logic [AW-1:0]         tgt;
   logic [CW-1:0]         lane;

   // Control FSM, stage-1 capture, drain index and sticky error.
   always_comb begin
      state_d   = state_q;
      s1_vld_d  = 1'b0;
      s1_idx_d  = s1_idx_q;
      s1_dat_d  = s1_dat_q;
      out_idx_d = out_idx_q;
      err_d     = err_q;
      clr       = 1'b0;
      // a lane may wrap once; anything reaching the second wrap is rejected whole
      beat_oor  = (13'(idx_B) + 13'(LANES - 1)) >= 13'(2 * DEPTH);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               clr     = 1'b1;
               err_d   = 1'b0;
               state_d = S_ACCUM;
            end
            if (B_valid) err_d = 1'b1;
         end
         S_ACCUM: begin
            if (start) begin
               // re-clear; the beat now in stage 1 and any concurrent beat are discarded
               clr = 1'b1;
            end else if (B_valid) begin
               if (beat_oor) begin
                  err_d = 1'b1;
               end else begin
                  s1_vld_d = 1'b1;
                  s1_idx_d = idx_B;
                  s1_dat_d = B_out;
               end
               if (B_last) state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            // stage 2 retires the final beat during this cycle
            if (B_valid) err_d = 1'b1;
            out_idx_d = '0;
            state_d   = S_DRAIN;
         end
         S_DRAIN: begin
            if (B_valid) err_d = 1'b1;
            if (out_ready) begin
               if (out_idx_q == AW'(DEPTH - 1)) begin
                  state_d = S_DONE;
               end else begin
                  out_idx_d = out_idx_q + AW'(1);
               end
            end
         end
         S_DONE: begin
            if (B_valid) err_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Stage 2: read-modify-write of the array. Lanes of one beat hit distinct
   // entries, and successive beats retire on successive edges, so no update is lost.
   always_comb begin
      mem_d = mem_q;
      tsum  = '0;
      wrap  = 1'b0;
      tgt   = '0;
      lane  = '0;
      if (clr) begin
         mem_d = '{default: '0};
      end else if (s1_vld_q) begin
         for (int k = 0; k < LANES; k++) begin
            tsum = 13'(s1_idx_q) + 13'(k);
            wrap = tsum >= 13'(DEPTH);
            if (wrap) tsum = tsum - 13'(DEPTH);
            tgt  = AW'(tsum);
            lane = s1_dat_q[k*CW +: CW];
`ifdef ACC_NEGACYCLIC_EN
            if (wrap) mem_d[tgt] = mem_d[tgt] - lane;
            else      mem_d[tgt] = mem_d[tgt] + lane;
`else
            mem_d[tgt] = mem_d[tgt] + lane;
`endif
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= S_IDLE;
         s1_vld_q  <= 1'b0;
         s1_idx_q  <= '0;
         s1_dat_q  <= '0;
         out_idx_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         s1_vld_q  <= s1_vld_d;
         s1_idx_q  <= s1_idx_d;
         s1_dat_q  <= s1_dat_d;
         out_idx_q <= out_idx_d;
         err_q     <= err_d;
      end
   end

   // Array contents are deliberately not reset; start is the only clear.
   always_ff @(posedge clk_in) begin
      mem_q <= mem_d;
   end

   assign out_valid = (state_q == S_DRAIN);
   assign out_idx   = 10'(out_idx_q);
   assign out_coeff = out_valid ? mem_q[out_idx_q] : '0;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign err       = err_q;

endmodule

// File: tb/tb_poly_product_accumulator.sv
// Randomized, scoreboard-checked bench for poly_product_accumulator.
// Expected drains are computed from a plain ring-polynomial model and queued at stimulus time;
// a negedge monitor compares every presented coefficient against the queue head.
module tb_poly_product_accumulator;

   localparam int DEPTH = 784;
   localparam int LANES = 7;
   localparam int CW    = 6;
   localparam int BW    = LANES * CW;
   localparam int CMASK = (1 << CW) - 1;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          start;
   logic          B_valid;
   logic [10:0]   idx_B;
   logic [BW-1:0] B_out;
   logic          B_last;
   logic          out_ready;
   logic          out_valid;
   logic [9:0]    out_idx;
   logic [CW-1:0] out_coeff;
   logic          busy;
   logic          done;
   logic          err;

   int checks   = 0;
   int failures = 0;
   int hs_cnt   = 0;
   int done_cnt = 0;

   int model [DEPTH];
   bit model_err;

   typedef struct {
      int idx;
      int coeff;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk_in = ~clk_in;

   poly_product_accumulator #(.DEPTH(DEPTH), .LANES(LANES), .CW(CW)) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .start     (start),
      .B_valid   (B_valid),
      .idx_B     (idx_B),
      .B_out     (B_out),
      .B_last    (B_last),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_idx   (out_idx),
      .out_coeff (out_coeff),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: compare against the scoreboard head whenever a coefficient is presented,
   // retire it on handshake. A stalled output must keep matching the same head entry.
   always @(negedge clk_in) begin
      if (done) done_cnt++;
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: idx=%0d coeff=%0d, expected no output", out_idx, out_coeff);
         end else begin
            check("out_idx", int'(out_idx), exp_q[0].idx);
            check("out_coeff", int'(out_coeff), exp_q[0].coeff);
            if (out_ready) begin
               void'(exp_q.pop_front());
               hs_cnt++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   function automatic logic [BW-1:0] pack(input int first, input int step);
      logic [BW-1:0] b;
      b = '0;
      for (int k = 0; k < LANES; k++) b[k*CW +: CW] = CW'(first + k * step);
      return b;
   endfunction

   // Reference: coefficient t of the ring polynomial; a lane past DEPTH folds back once,
   // multiplied by x^DEPTH = +1 (cyclic) or -1 (negacyclic).
   task automatic model_apply(input int idx, input logic [BW-1:0] bus);
      int t;
      int v;
      if (idx + LANES - 1 >= 2 * DEPTH) begin
         model_err = 1'b1;
      end else begin
         for (int k = 0; k < LANES; k++) begin
            t = idx + k;
            v = int'((bus >> (k * CW)) & BW'(CMASK));
            if (t >= DEPTH) begin
               t = t - DEPTH;
`ifdef ACC_NEGACYCLIC_EN
               v = -v;
`endif
            end
            model[t] = (model[t] + v) & CMASK;
         end
      end
   endtask

   task automatic do_start(input bit from_idle);
      start = 1'b1;
      tick();
      start = 1'b0;
      foreach (model[i]) model[i] = 0;
      if (from_idle) model_err = 1'b0;
   endtask

   task automatic send_beat(input int idx, input logic [BW-1:0] bus, input bit last);
      B_valid = 1'b1;
      idx_B   = 11'(idx);
      B_out   = bus;
      B_last  = last;
      tick();
      B_valid = 1'b0;
      B_last  = 1'b0;
      model_apply(idx, bus);
   endtask

   // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1.
   // abort_at >= 0 pulses reset once that many coefficients have been handed over.
   task automatic drain(input int mode, input int abort_at);
      int d0;
      int h0;
      bit pat [4];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      d0 = done_cnt;
      h0 = hs_cnt;
      for (int i = 0; i < DEPTH; i++) exp_q.push_back('{idx: i, coeff: model[i]});
      for (int c = 0; c < 8000; c++) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = pat[c % 4];
         endcase
         tick();
         if (abort_at >= 0 && hs_cnt - h0 == abort_at) begin
            check("abort_idx", int'(out_idx), abort_at);
            rst_in = 1'b1;
            #1;
            check("abort_out_valid", int'(out_valid), 0);
            check("abort_busy", int'(busy), 0);
            check("abort_out_idx", int'(out_idx), 0);
            check("abort_err", int'(err), 0);
            exp_q.delete();
            tick();
            rst_in    = 1'b0;
            model_err = 1'b0;
            tick();
            check("abort_no_valid", int'(out_valid), 0);
            check("abort_hs_stopped", hs_cnt - h0, abort_at);
            out_ready = 1'b0;
            return;
         end
         if (done_cnt != d0) break;
      end
      out_ready = 1'b0;
      tick();
      check("done_pulses", done_cnt - d0, 1);
      check("handshakes", hs_cnt - h0, DEPTH);
      check("sb_empty", exp_q.size(), 0);
      check("busy_after_done", int'(busy), 0);
      check("err_after_drain", int'(err), int'(model_err));
   endtask

   initial begin
      int nb;
      int idx;
      logic [63:0] r;

      rst_in    = 1'b1;
      start     = 1'b0;
      B_valid   = 1'b0;
      B_last    = 1'b0;
      idx_B     = '0;
      B_out     = '0;
      out_ready = 1'b0;
      model_err = 1'b0;
      foreach (model[i]) model[i] = 0;

      #12;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_idx", int'(out_idx), 0);
      check("rst_out_coeff", int'(out_coeff), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);
      tick();
      rst_in = 1'b0;
      tick();

      // single ramp beat at index 0
      do_start(1'b1);
      check("busy_accum", int'(busy), 1);
      send_beat(0, pack(1, 1), 1'b1);
      drain(0, -1);

      // back-to-back overlapping beats, both must land
      do_start(1'b1);
      send_beat(3, pack(63, 0), 1'b0);
      send_beat(5, pack(2, 0), 1'b1);
      drain(1, -1);

      // beat straddling the ring end, drained with a 1,0,0,1 ready pattern
      do_start(1'b1);
      send_beat(780, pack(5, 0), 1'b1);
      drain(2, -1);

      // out-of-range beat is dropped and flags err
      do_start(1'b1);
      send_beat(1565, pack(9, 0), 1'b0);
      tick();
      check("err_oor", int'(err), 1);
      send_beat(10, pack(3, 1), 1'b1);
      drain(0, -1);

      // start clears err; B_valid in IDLE sets it again; next start clears it
      do_start(1'b1);
      check("err_clr_start", int'(err), 0);
      send_beat(0, pack(0, 0), 1'b1);
      drain(0, -1);
      B_valid = 1'b1;
      idx_B   = 11'd4;
      B_out   = pack(7, 0);
      tick();
      B_valid   = 1'b0;
      model_err = 1'b1;
      tick();
      check("err_idle_beat", int'(err), 1);
      do_start(1'b1);
      check("err_clr_idle", int'(err), 0);

      // restart inside ACCUM while a beat sits in stage 1
      send_beat(100, pack(11, 3), 1'b0);
      do_start(1'b0);
      send_beat(200, pack(4, 5), 1'b1);
      drain(0, -1);

      // randomized products
      for (int run = 0; run < 4; run++) begin
         do_start(1'b1);
         nb = $urandom_range(1, 20);
         for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 7) == 0 && b != nb - 1)
               idx = $urandom_range(2 * DEPTH - LANES + 1, 2047);
            else
               idx = $urandom_range(0, 2 * DEPTH - LANES);
            r = {$urandom(), $urandom()};
            send_beat(idx, BW'(r), b == nb - 1);
            if (b != nb - 1) begin
               if ($urandom_range(0, 15) == 0) do_start(1'b0);
               repeat ($urandom_range(0, 2)) tick();
            end
         end
         drain(1, -1);
      end

      // reset in the middle of a drain, then an all-zero product
      do_start(1'b1);
      send_beat(700, pack(3, 0), 1'b1);
      drain(0, 100);
      do_start(1'b1);
      send_beat(0, pack(0, 0), 1'b1);
      drain(0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
